// File: rtl/kinase_valve_sequencer.sv
// Pneumatic valve sequencer for one kinase assay run: reagent fill, peristaltic mix,
// column transfer, elution. Optional pause input enabled by defining KINASE_SEQ_PAUSE_EN.
module kinase_valve_sequencer #(
   parameter int DWELL_W       = 16,
   parameter int MIXC_W        = 8,
   parameter int PUMP_STEP_CYC = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               abort,
`ifdef KINASE_SEQ_PAUSE_EN
   input  logic               pause,
`endif
   input  logic [1:0]         reagent_sel,
   input  logic               collect_sel,
   input  logic [MIXC_W-1:0]  mix_cycles,
   input  logic [DWELL_W-1:0] fill_time,
   input  logic [DWELL_W-1:0] xfer_time,
   input  logic [DWELL_W-1:0] elute_time,
   output logic [12:0]        c_air,
   output logic [3:0]         s_air,
   output logic [4:0]         p_air,
   output logic               busy,
   output logic               done
);

   localparam int STEP_W = (PUMP_STEP_CYC > 1) ? $clog2(PUMP_STEP_CYC) : 1;
   localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(PUMP_STEP_CYC - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_FILL, S_MIX, S_XFER, S_ELUTE, S_DONE
   } state_t;

   state_t               state, state_n;
   logic [DWELL_W-1:0]   dwell, dwell_n;
   logic [MIXC_W-1:0]    mix_rem, mix_rem_n;
   logic [STEP_W-1:0]    step_cnt, step_cnt_n;
   logic [2:0]           step_idx, step_idx_n;
   logic [1:0]           rsel_q;
   logic                 csel_q;
   logic [DWELL_W-1:0]   xfer_q, elute_q;

   logic                 launch, freeze;
   logic                 step_wrap, cyc_wrap;
   logic [STEP_W-1:0]    adv_cnt;
   logic [2:0]           adv_idx;
   logic [1:0]           inlet_sel;
   logic [12:0]          c_n;
   logic [3:0]           s_n;
   logic [4:0]           p_n;
   logic                 busy_n, done_n;

   function automatic logic [DWELL_W-1:0] at_least_one(input logic [DWELL_W-1:0] t);
      return (t == '0) ? DWELL_W'(1) : t;
   endfunction

   // {p3,p2,p1} peristaltic sequence, 0 = vented
   function automatic logic [2:0] pump_pat(input logic [2:0] idx);
      case (idx)
         3'd0:    return 3'b110;
         3'd1:    return 3'b100;
         3'd2:    return 3'b101;
         3'd3:    return 3'b001;
         3'd4:    return 3'b011;
         3'd5:    return 3'b010;
         default: return 3'b111;
      endcase
   endfunction

   assign launch = (state == S_IDLE) && start;

`ifdef KINASE_SEQ_PAUSE_EN
   assign freeze = pause && !abort && (state inside {S_FILL, S_MIX, S_XFER, S_ELUTE});
`else
   assign freeze = 1'b0;
`endif

   always_comb begin
      step_wrap = (step_cnt == STEP_LAST);
      cyc_wrap  = step_wrap && (step_idx == 3'd5);
      adv_cnt   = step_wrap ? '0 : step_cnt + STEP_W'(1);
      if (!step_wrap)
         adv_idx = step_idx;
      else if (step_idx == 3'd5)
         adv_idx = 3'd0;
      else
         adv_idx = step_idx + 3'd1;
   end

   always_comb begin
      state_n    = state;
      dwell_n    = dwell;
      mix_rem_n  = mix_rem;
      step_cnt_n = step_cnt;
      step_idx_n = step_idx;
      if (abort && state != S_IDLE) begin
         state_n = S_IDLE;
      end else if (!freeze) begin
         case (state)
            S_IDLE: if (start) begin
               state_n   = S_FILL;
               dwell_n   = at_least_one(fill_time);
               mix_rem_n = mix_cycles;
            end
            S_FILL: begin
               step_cnt_n = '0;
               step_idx_n = 3'd0;
               if (dwell == DWELL_W'(1)) begin
                  if (mix_rem == '0) begin
                     state_n = S_XFER;
                     dwell_n = at_least_one(xfer_q);
                  end else begin
                     state_n = S_MIX;
                  end
               end else begin
                  dwell_n = dwell - DWELL_W'(1);
               end
            end
            S_MIX: begin
               step_cnt_n = adv_cnt;
               step_idx_n = adv_idx;
               if (cyc_wrap) begin
                  if (mix_rem == MIXC_W'(1)) begin
                     state_n = S_XFER;
                     dwell_n = at_least_one(xfer_q);
                  end else begin
                     mix_rem_n = mix_rem - MIXC_W'(1);
                  end
               end
            end
            // the pump keeps stepping; the dwell alone decides when transfer ends
            S_XFER: begin
               step_cnt_n = adv_cnt;
               step_idx_n = adv_idx;
               if (dwell == DWELL_W'(1)) begin
                  state_n = S_ELUTE;
                  dwell_n = at_least_one(elute_q);
               end else begin
                  dwell_n = dwell - DWELL_W'(1);
               end
            end
            S_ELUTE: begin
               if (dwell == DWELL_W'(1))
                  state_n = S_DONE;
               else
                  dwell_n = dwell - DWELL_W'(1);
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
         endcase
      end
   end

   // Output pattern is derived from the state being entered so it lands registered
   // in the first cycle of that state.
   always_comb begin
      c_n       = 13'h1FFF;
      s_n       = 4'hF;
      p_n       = 5'h1F;
      busy_n    = 1'b0;
      done_n    = 1'b0;
      inlet_sel = launch ? reagent_sel : rsel_q;
      case (state_n)
         S_FILL: begin
            case (inlet_sel)
               2'd1:    c_n[1] = 1'b0;
               2'd2:    c_n[2] = 1'b0;
               default: c_n[0] = 1'b0;
            endcase
            c_n[3]   = 1'b0;
            c_n[4]   = 1'b0;
            c_n[7]   = 1'b0;
            p_n[2:0] = 3'b000;
            busy_n   = 1'b1;
         end
         S_MIX: begin
            c_n[4]   = 1'b0;
            p_n[2:0] = pump_pat(step_idx_n);
            busy_n   = 1'b1;
         end
         S_XFER: begin
            c_n[6]   = 1'b0;
            c_n[8]   = 1'b0;
            c_n[9]   = 1'b0;
            s_n[2]   = 1'b0;
            p_n[2:0] = pump_pat(step_idx_n);
            busy_n   = 1'b1;
         end
         S_ELUTE: begin
            if (csel_q)
               c_n[12] = 1'b0;
            else
               c_n[11] = 1'b0;
            s_n[3] = 1'b0;
            busy_n = 1'b1;
         end
         S_DONE:  done_n = 1'b1;
         default: ;
      endcase
      if (freeze) begin
         c_n = 13'h1FFF;
         s_n = 4'hF;
         p_n = p_air;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         dwell    <= '0;
         mix_rem  <= '0;
         step_cnt <= '0;
         step_idx <= 3'd0;
         rsel_q   <= 2'd0;
         csel_q   <= 1'b0;
         xfer_q   <= '0;
         elute_q  <= '0;
         c_air    <= 13'h1FFF;
         s_air    <= 4'hF;
         p_air    <= 5'h1F;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_n;
         dwell    <= dwell_n;
         mix_rem  <= mix_rem_n;
         step_cnt <= step_cnt_n;
         step_idx <= step_idx_n;
         c_air    <= c_n;
         s_air    <= s_n;
         p_air    <= p_n;
         busy     <= busy_n;
         done     <= done_n;
         if (launch) begin
            rsel_q  <= reagent_sel;
            csel_q  <= collect_sel;
            xfer_q  <= xfer_time;
            elute_q <= elute_time;
         end
      end
   end

endmodule

// File: tb/tb_kinase_valve_sequencer.sv
// Bench for kinase_valve_sequencer: per-cycle output trace scoreboard plus scenario checks.
module tb_kinase_valve_sequencer;

   localparam int DW   = 16;
   localparam int MW   = 8;
   localparam int STEP = 4;
   localparam logic [23:0] IDLE_V = {1'b0, 1'b0, 5'h1F, 4'hF, 13'h1FFF};

   logic          clk;
   logic          rst_n;
   logic          start;
   logic          abort;
`ifdef KINASE_SEQ_PAUSE_EN
   logic          pause;
`endif
   logic [1:0]    reagent_sel;
   logic          collect_sel;
   logic [MW-1:0] mix_cycles;
   logic [DW-1:0] fill_time, xfer_time, elute_time;
   logic [12:0]   c_air;
   logic [3:0]    s_air;
   logic [4:0]    p_air;
   logic          busy, done;

   int            n_checks;
   int            n_fail;
   logic [23:0]   exp_q[$];
   int            push_lim;
   int            push_cnt;
   logic [2:0]    pat [6] = '{3'b110, 3'b100, 3'b101, 3'b001, 3'b011, 3'b010};

   kinase_valve_sequencer #(
      .DWELL_W(DW), .MIXC_W(MW), .PUMP_STEP_CYC(STEP)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
`ifdef KINASE_SEQ_PAUSE_EN
      .pause(pause),
`endif
      .reagent_sel(reagent_sel), .collect_sel(collect_sel), .mix_cycles(mix_cycles),
      .fill_time(fill_time), .xfer_time(xfer_time), .elute_time(elute_time),
      .c_air(c_air), .s_air(s_air), .p_air(p_air), .busy(busy), .done(done)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [23:0] vec(input logic b, input logic d, input logic [4:0] p,
                                       input logic [3:0] s, input logic [12:0] c);
      return {b, d, p, s, c};
   endfunction

   task automatic push1(input logic [23:0] v);
      if (push_cnt < push_lim) exp_q.push_back(v);
      push_cnt++;
   endtask

   // expected cycle-by-cycle trace of one run; pause_at is an XFER cycle index (>=1)
   task automatic push_run(input int rsel, input int csel, input int mix, input int fill,
                           input int xfer, input int elute, input int pause_at, input int pause_len);
      logic [12:0] c;
      logic [4:0]  p, last_p;
      int          f, x, e;
      f = (fill == 0) ? 1 : fill;
      x = (xfer == 0) ? 1 : xfer;
      e = (elute == 0) ? 1 : elute;
      c = 13'h1FFF;
      c[(rsel == 1) ? 1 : (rsel == 2) ? 2 : 0] = 1'b0;
      c[3] = 1'b0; c[4] = 1'b0; c[7] = 1'b0;
      for (int i = 0; i < f; i++) push1(vec(1'b1, 1'b0, 5'b11000, 4'hF, c));
      c = 13'h1FFF; c[4] = 1'b0;
      for (int k = 0; k < mix * 6 * STEP; k++)
         push1(vec(1'b1, 1'b0, {2'b11, pat[(k / STEP) % 6]}, 4'hF, c));
      c = 13'h1FFF; c[6] = 1'b0; c[8] = 1'b0; c[9] = 1'b0;
      last_p = 5'h1F;
      for (int i = 0; i < x; i++) begin
         if (i == pause_at)
            for (int j = 0; j < pause_len; j++) push1(vec(1'b1, 1'b0, last_p, 4'hF, 13'h1FFF));
         p = {2'b11, pat[(i / STEP) % 6]};
         push1(vec(1'b1, 1'b0, p, 4'b1011, c));
         last_p = p;
      end
      c = 13'h1FFF; c[(csel != 0) ? 12 : 11] = 1'b0;
      for (int i = 0; i < e; i++) push1(vec(1'b1, 1'b0, 5'h1F, 4'b0111, c));
      push1(vec(1'b0, 1'b1, 5'h1F, 4'hF, 13'h1FFF));
   endtask

   // driver: apply a configuration and queue its expected trace
   task automatic arm(input int rsel, input int csel, input int mix, input int fill,
                      input int xfer, input int elute, input int pause_at, input int pause_len);
      reagent_sel = 2'(rsel);
      collect_sel = 1'(csel);
      mix_cycles  = MW'(mix);
      fill_time   = DW'(fill);
      xfer_time   = DW'(xfer);
      elute_time  = DW'(elute);
      push_cnt    = 0;
      push_run(rsel, csel, mix, fill, xfer, elute, pause_at, pause_len);
   endtask

   function automatic int run_len(input int mix, input int fill, input int xfer, input int elute);
      return ((fill == 0) ? 1 : fill) + mix * 6 * STEP + ((xfer == 0) ? 1 : xfer)
             + ((elute == 0) ? 1 : elute) + 1;
   endfunction

   // scoreboard: advance one cycle, pop the expected output vector and compare
   task automatic sb_cycle(input string name, input int t);
      logic [23:0] got, exp;
      @(posedge clk);
      #1;
      got = {busy, done, p_air, s_air, c_air};
      exp = IDLE_V;
      if (exp_q.size() > 0) exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s t=%0d got busy=%b done=%b p=%h s=%h c=%h required busy=%b done=%b p=%h s=%h c=%h",
                  name, t, got[23], got[22], got[21:17], got[16:13], got[12:0],
                  exp[23], exp[22], exp[21:17], exp[16:13], exp[12:0]);
      end
      n_checks++;
      if ($countones(~c_air[2:0]) > 1 || (!c_air[11] && !c_air[12]) ||
          p_air[4:3] !== 2'b11 || s_air[1:0] !== 2'b11) begin
         n_fail++;
         $display("FAIL invariants %s t=%0d got c=%h s=%h p=%h required exclusive inlets/outlets and reserved lines closed",
                  name, t, c_air, s_air, p_air);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int t = 1; t <= 3; t++) sb_cycle("reset", t);
      rst_n = 1'b1;
      sb_cycle("reset_release", 4);
   endtask

   task automatic test_normal();
      int done_at;
      done_at = 0;
      arm(1, 0, 2, 5, 10, 3, -1, 0);
      start = 1'b1;
      for (int t = 1; t <= 70; t++) begin
         sb_cycle("normal", t);
         if (t == 1) start = 1'b0;
         if (done === 1'b1 && done_at == 0) done_at = t;
      end
      n_checks++;
      if (done_at !== 67) begin
         n_fail++;
         $display("FAIL normal_done_cycle got %0d required 67", done_at);
      end
   endtask

   task automatic test_zero_skip();
      int busy_cnt;
      busy_cnt = 0;
      arm(0, 0, 0, 0, 0, 0, -1, 0);
      start = 1'b1;
      for (int t = 1; t <= 8; t++) begin
         sb_cycle("zero_skip", t);
         if (busy === 1'b1) busy_cnt++;
         if (t == 5) start = 1'b0;
      end
      n_checks++;
      if (busy_cnt !== 3) begin
         n_fail++;
         $display("FAIL zero_skip_busy got %0d required 3", busy_cnt);
      end
   endtask

   task automatic test_abort();
      int dones;
      dones = 0;
      push_lim = 5;
      arm(2, 0, 3, 2, 6, 2, -1, 0);
      push_lim = 1 << 30;
      start = 1'b1;
      for (int t = 1; t <= 12; t++) begin
         sb_cycle("abort", t);
         if (t == 1) start = 1'b0;
         if (done === 1'b1) dones++;
         if (t == 5) abort = 1'b1;
         if (t == 6) abort = 1'b0;
         if (t == 8) abort = 1'b1;
         if (t == 9) abort = 1'b0;
      end
      n_checks++;
      if (dones !== 0) begin
         n_fail++;
         $display("FAIL abort_no_done got %0d done pulses required 0", dones);
      end
      dones = 0;
      arm(0, 1, 1, 1, 2, 1, -1, 0);
      start = 1'b1;
      for (int t = 1; t <= run_len(1, 1, 2, 1) + 1; t++) begin
         sb_cycle("after_abort", t);
         if (t == 1) start = 1'b0;
         if (done === 1'b1) dones++;
      end
      n_checks++;
      if (dones !== 1) begin
         n_fail++;
         $display("FAIL after_abort_done got %0d done pulses required 1", dones);
      end
   endtask

   task automatic test_collect();
      int c13_cnt, c1_cnt;
      c13_cnt = 0;
      c1_cnt  = 0;
      arm(3, 1, 1, 3, 5, 4, -1, 0);
      start = 1'b1;
      for (int t = 1; t <= run_len(1, 3, 5, 4) + 1; t++) begin
         sb_cycle("collect", t);
         if (t == 1) start = 1'b0;
         if (c_air[12] === 1'b0) c13_cnt++;
         if (c_air[0] === 1'b0) c1_cnt++;
      end
      n_checks++;
      if (c13_cnt !== 4 || c1_cnt !== 3) begin
         n_fail++;
         $display("FAIL collect_paths got c13=%0d c1=%0d open cycles required 4 and 3", c13_cnt, c1_cnt);
      end
   endtask

   task automatic test_reset_mid();
      arm(1, 1, 2, 3, 4, 2, -1, 0);
      start = 1'b1;
      for (int t = 1; t <= 10; t++) begin
         sb_cycle("pre_reset", t);
         if (t == 1) start = 1'b0;
      end
      rst_n = 1'b0;
      exp_q.delete();
      for (int t = 1; t <= 2; t++) sb_cycle("mid_reset", t);
      rst_n = 1'b1;
   endtask

   task automatic test_back_to_back();
      int rs, cs, mx, fl, xf, el;
      for (int r = 0; r < 5; r++) begin
         rs = $urandom_range(0, 3);
         cs = $urandom_range(0, 1);
         mx = $urandom_range(0, 2);
         fl = $urandom_range(0, 4);
         xf = $urandom_range(0, 9);
         el = $urandom_range(0, 4);
         arm(rs, cs, mx, fl, xf, el, -1, 0);
         start = 1'b1;
         for (int t = 1; t <= run_len(mx, fl, xf, el) + 1; t++) begin
            sb_cycle("back_to_back", t);
            if (t == 1) start = 1'b0;
         end
      end
   endtask

`ifdef KINASE_SEQ_PAUSE_EN
   task automatic test_pause();
      int xfer_open;
      xfer_open = 0;
      arm(0, 0, 1, 2, 20, 2, 10, 7);
      start = 1'b1;
      for (int t = 1; t <= 60; t++) begin
         sb_cycle("pause", t);
         if (t == 1) start = 1'b0;
         if (c_air === 13'h1CBF && s_air === 4'b1011) xfer_open++;
         if (t == 36) pause = 1'b1;
         if (t == 43) pause = 1'b0;
      end
      n_checks++;
      if (xfer_open !== 20) begin
         n_fail++;
         $display("FAIL pause_xfer_time got %0d open cycles required 20", xfer_open);
      end
   endtask
`endif

   initial begin
      n_checks    = 0;
      n_fail      = 0;
      push_lim    = 1 << 30;
      push_cnt    = 0;
      rst_n       = 1'b0;
      start       = 1'b0;
      abort       = 1'b0;
`ifdef KINASE_SEQ_PAUSE_EN
      pause       = 1'b0;
`endif
      reagent_sel = 2'd0;
      collect_sel = 1'b0;
      mix_cycles  = '0;
      fill_time   = '0;
      xfer_time   = '0;
      elute_time  = '0;
      test_reset();
      test_normal();
      test_zero_skip();
      test_abort();
      test_collect();
      test_reset_mid();
      test_back_to_back();
`ifdef KINASE_SEQ_PAUSE_EN
      test_pause();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/kinase_valve_sequencer.md
Name: kinase_valve_sequencer

Overview:
- Synchronous controller that drives the pneumatic control lines of the kinase-activity chip through one assay run: reagent fill, peristaltic mixing, column transfer, then elution to collect or waste.
- Sits between the host/config registers and the off-chip solenoid bank.
- Every valve air line is a registered output.
- Air line convention: 1 = pressurized = valve closed; 0 = vented = valve open.

Parameters:
- DWELL_W, 16, width of each phase dwell counter and dwell config input.
- MIXC_W, 8, width of the mix-cycle count input.
- PUMP_STEP_CYC, 4, clock cycles per peristaltic step (must be ≥1).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  begin run; sampled only in IDLE.
- abort  input  1  synchronous abort.
- reagent_sel  input  2  inlet select: 0→v1, 1→v2, 2→v3, 3 reserved (treated as 0).
- collect_sel  input  1  0 = elute to out3 (v12), 1 = elute to out4 (v13).
- mix_cycles  input  MIXC_W  full 6-step pump cycles in MIX.
- fill_time, xfer_time, elute_time  input  DWELL_W each  phase dwells in cycles.
- c_air  output  13  air lines c1..c13 (bit0 = c1).
- s_air  output  4  air lines s1..s4.
- p_air  output  5  air lines p1..p5.
- busy  output  1  high from FILL through ELUTE.
- done  output  1  one-cycle pulse on run completion.

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE; c_air=13'h1FFF, s_air=4'hF, p_air=5'h1F (all closed); busy=0; done=0; counters cleared.
- Outputs are registered. Values for state X appear the cycle after the edge that enters X.
- IDLE:
  - All valves closed.
  - start=1 latches reagent_sel, collect_sel, mix_cycles and the three dwells, then goes to FILL.
  - start is ignored in all other states.
- FILL:
  - Open the selected inlet, v4, v5, v8, and p1, p2, p3.
  - Hold max(1, fill_time) cycles.
  - Then go to MIX, or to XFER if mix_cycles==0.
- MIX:
  - v5 open; all other c/s lines closed.
  - p1..p3 step through the pattern {p3p2p1} = 110, 100, 101, 001, 011, 010.
  - Each step lasts PUMP_STEP_CYC cycles.
  - After mix_cycles full 6-step cycles, go to XFER.
  - The step index resets to 0 on MIX entry.
- XFER:
  - Open v7, v9, v10 and s3.
  - The pump pattern continues from step 0 with the same step timing.
  - Hold max(1, xfer_time) cycles; the pump step is cut wherever the dwell ends.
  - Then go to ELUTE.
- ELUTE:
  - Open s4, plus v12 (collect_sel=0) or v13 (collect_sel=1). p1..p3 are closed.
  - Hold max(1, elute_time) cycles, then go to DONE.
- DONE:
  - All valves closed; done=1 for exactly this one cycle; busy=0.
  - Next state is IDLE.
- Invariants, checkable every cycle:
  - At most one of c1..c3 is open.
  - v12 and v13 are never both open.
  - p4 and p5 stay closed and are reserved.
  - s1 and s2 stay closed and are reserved.
- abort=1 in any non-IDLE state:
  - Next state is IDLE with all valves closed; busy=0; done stays 0.
  - abort in IDLE has no effect.
  - abort takes priority over a dwell expiring in the same cycle.
- Reset mid-run behaves identically to power-on reset.
- Dwell counters count down from the latched value; a latched 0 is treated as 1.
- The mix-cycle counter is MIXC_W bits and does not wrap: maximum 2^MIXC_W−1 cycles.

Optional Feature:
- Macro: KINASE_SEQ_PAUSE_EN.
- When defined, adds input pause (1 bit).
- While pause=1 in FILL, MIX, XFER or ELUTE:
  - State, dwell counter, pump step index and cycle count freeze.
  - c_air and s_air go all-closed.
  - p_air holds its current value so the peristaltic position is preserved.
  - On release, the previous valve pattern is restored the next cycle and counting resumes.
- busy stays 1 during pause. abort overrides pause.
- When not defined, there is no port and no logic.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles → c_air=1FFF, s_air=F, p_air=1F, busy=0, done=0.
- Normal run: reagent_sel=1, fill_time=5, mix_cycles=2, PUMP_STEP_CYC=4, xfer_time=10, elute_time=3, collect_sel=0, start pulse → expect:
  - FILL 5 cycles with c2, c4, c5, c8 open;
  - MIX 48 cycles with the exact p pattern;
  - XFER 10 cycles; ELUTE 3 cycles with c12 and s4 open;
  - done pulse at cycle 67 after the start edge.
- Zero and skip cases: mix_cycles=0 and all dwells=0 → FILL 1, XFER 1, ELUTE 1 cycle, done 4 cycles after start; start held high through the run causes no restart.
- Abort: abort in cycle 3 of MIX → next cycle all closed, IDLE, busy=0, no done pulse; a new start works normally.
- Collect path and reserved select: collect_sel=1, reagent_sel=3 → c13 opens in ELUTE and c1 in FILL; assertion that c12/c13 and c1..c3 exclusivity never fail.
- Pause (macro defined): pause for 7 cycles mid-XFER → p_air frozen, c_air/s_air all closed; total XFER open-time still equals xfer_time.
